// File: rtl/player_anim_sequencer.sv
// Player sprite animation sequencer: selects the active animation from controls and platform
// contact, and steps its frame index on frame_clk ticks. Optional DEAD animation: PLAYER_DEATH_ANIM_EN.
module player_anim_sequencer #(
  parameter int unsigned FRAME_HOLD  = 4,
  parameter int unsigned RUN_FRAMES  = 6,
  parameter int unsigned DIAG_FRAMES = 3,
  parameter int unsigned JUMP_FRAMES = 4,
  parameter int unsigned DEAD_FRAMES = 3,
  parameter logic [1:0]  PLAY_STATE  = 2'd1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [1:0] gameState,
  input  logic [4:0] keycode,
  input  logic       keyPress,
  input  logic       onPlatform,
  input  logic       playerMoving,
  input  logic       hit,
  output logic [2:0] animState,
  output logic [2:0] animFrame,
  output logic       facing,
  output logic       stateChanged,
  output logic       deadDone
);

  localparam int unsigned HoldW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(FRAME_HOLD - 1);

  typedef enum logic [2:0] {
    StWait   = 3'd0,
    StRun    = 3'd1,
    StDown   = 3'd2,
    StUp     = 3'd3,
    StDownRl = 3'd4,
    StUpRl   = 3'd5,
    StJump   = 3'd6,
    StDead   = 3'd7
  } anim_state_e;

  anim_state_e stateQ, stateD, keyState, target;
  logic [2:0]       frameQ, frameD, lastQ;
  logic [HoldW-1:0] holdQ, holdD;
  logic             facingQ, facingD;
  logic             jumpAgedQ, jumpAgedD;
  logic             stateChangedQ, stateChangedD;
  logic             frameClkQ;
  logic             tick, inPlay, deathHit;
  logic [4:0]       keys;
  logic             left, right, up, down, effUp, effDown, anyLr;

  function automatic logic [2:0] lastFrame(input anim_state_e st);
    case (st)
      StRun:            lastFrame = 3'(RUN_FRAMES - 1);
      StDownRl, StUpRl: lastFrame = 3'(DIAG_FRAMES - 1);
      StJump:           lastFrame = 3'(JUMP_FRAMES - 1);
      StDead:           lastFrame = 3'(DEAD_FRAMES - 1);
      default:          lastFrame = 3'd0;
    endcase
  endfunction

  assign tick    = frame_clk & ~frameClkQ;
  assign inPlay  = (gameState == PLAY_STATE);
  assign keys    = keyPress ? keycode : 5'd0;
  assign left    = keys[0];
  assign right   = keys[1];
  assign up      = keys[2];
  assign down    = keys[3];
  // Up and down together cancel each other out.
  assign effUp   = up & ~down;
  assign effDown = down & ~up;
  assign anyLr   = left | right;
  assign lastQ   = lastFrame(stateQ);

  always_comb begin
    keyState = StWait;
    if (effDown && anyLr) begin
      keyState = StDownRl;
    end else if (effUp && anyLr) begin
      keyState = StUpRl;
    end else if (effDown) begin
      keyState = StDown;
    end else if (effUp) begin
      keyState = StUp;
    end else if ((left ^ right) && playerMoving) begin
      keyState = StRun;
    end
  end

  always_comb begin
    target = keyState;
    if (stateQ == StDead) begin
      target = StDead;
    end else if (deathHit) begin
      target = StDead;
    end else if (stateQ == StJump) begin
      // Directional keys only matter once the jump has landed.
      target = (onPlatform && jumpAgedQ) ? keyState : StJump;
    end else if (keys[4] && onPlatform) begin
      target = StJump;
    end
  end

  always_comb begin
    stateD        = stateQ;
    frameD        = frameQ;
    holdD         = holdQ;
    facingD       = facingQ;
    jumpAgedD     = jumpAgedQ;
    stateChangedD = 1'b0;
    if (tick) begin
      if (!inPlay) begin
        stateD    = StWait;
        frameD    = 3'd0;
        holdD     = '0;
        jumpAgedD = 1'b0;
      end else begin
        if (left && !right) begin
          facingD = 1'b0;
        end else if (right && !left) begin
          facingD = 1'b1;
        end
        stateD = target;
        if (target != stateQ) begin
          frameD    = 3'd0;
          holdD     = '0;
          jumpAgedD = 1'b0;
        end else begin
          jumpAgedD = 1'b1;
          if (holdQ == HoldLast) begin
            holdD = '0;
            if (frameQ == lastQ) begin
              // DEAD saturates on its last frame; every other cycle wraps.
              frameD = (stateQ == StDead) ? frameQ : 3'd0;
            end else begin
              frameD = frameQ + 3'd1;
            end
          end else begin
            holdD = holdQ + HoldW'(1);
          end
        end
      end
      stateChangedD = (stateD != stateQ);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ        <= StWait;
      frameQ        <= 3'd0;
      holdQ         <= '0;
      facingQ       <= 1'b1;
      jumpAgedQ     <= 1'b0;
      stateChangedQ <= 1'b0;
      frameClkQ     <= 1'b0;
    end else begin
      stateQ        <= stateD;
      frameQ        <= frameD;
      holdQ         <= holdD;
      facingQ       <= facingD;
      jumpAgedQ     <= jumpAgedD;
      stateChangedQ <= stateChangedD;
      frameClkQ     <= frame_clk;
    end
  end

`ifdef PLAYER_DEATH_ANIM_EN
  logic deadDoneQ;

  assign deathHit = hit;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      deadDoneQ <= 1'b0;
    end else begin
      deadDoneQ <= (stateD == StDead) && (frameD == lastFrame(StDead));
    end
  end

  assign deadDone = deadDoneQ;
`else
  logic unusedHit;

  assign deathHit  = 1'b0;
  assign unusedHit = hit;
  assign deadDone  = 1'b0;
`endif

  assign animState    = stateQ;
  assign animFrame    = frameQ;
  assign facing       = facingQ;
  assign stateChanged = stateChangedQ;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Directed bench for player_anim_sequencer: table of tick-driven vectors plus hand-written
// sequences for reset/tick races, inter-tick key changes and the optional DEAD animation.
module tb_player_anim_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [1:0] gameState = 2'd1;
  logic [4:0] keycode = 5'd0;
  logic       keyPress = 1'b0;
  logic       onPlatform = 1'b0;
  logic       playerMoving = 1'b0;
  logic       hit = 1'b0;
  logic [2:0] animState;
  logic [2:0] animFrame;
  logic       facing;
  logic       stateChanged;
  logic       deadDone;

  int nChecks = 0;
  int nFails = 0;

  player_anim_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .gameState    (gameState),
    .keycode      (keycode),
    .keyPress     (keyPress),
    .onPlatform   (onPlatform),
    .playerMoving (playerMoving),
    .hit          (hit),
    .animState    (animState),
    .animFrame    (animFrame),
    .facing       (facing),
    .stateChanged (stateChanged),
    .deadDone     (deadDone)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] gs;
    logic [4:0] key;
    logic       kp;
    logic       onP;
    logic       mov;
    int         n;
    logic [2:0] st;
    logic [2:0] fr;
    logic       fac;
    logic       chg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] gs, input logic [4:0] key, input logic kp,
                     input logic onP, input logic mov, input int n, input logic [2:0] st,
                     input logic [2:0] fr, input logic fac, input logic chg);
    vec_t v;
    v.gs = gs; v.key = key; v.kp = kp; v.onP = onP; v.mov = mov; v.n = n;
    v.st = st; v.fr = fr; v.fac = fac; v.chg = chg;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame_clk rising edge; returns on the falling Clk edge after the update.
  task automatic tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  localparam logic [1:0] P = 2'd1;
  localparam logic [1:0] O = 2'd0;

  initial begin
    // gs key kp onP mov n | state frame facing changed
    add(P,  0, 0, 1, 0, 10, 0, 0, 1, 0);
    add(P,  2, 1, 1, 1,  1, 1, 0, 1, 1);
    add(P,  2, 1, 1, 1,  3, 1, 0, 1, 0);
    add(P,  2, 1, 1, 1,  1, 1, 1, 1, 0);
    add(P,  2, 1, 1, 1, 16, 1, 5, 1, 0);
    add(P,  2, 1, 1, 1,  4, 1, 0, 1, 0);
    add(P,  2, 0, 1, 1,  1, 0, 0, 1, 1);
    add(P,  1, 1, 1, 1,  1, 1, 0, 0, 1);
    add(P, 10, 1, 1, 1,  1, 4, 0, 1, 1);
    add(P, 10, 1, 1, 1,  4, 4, 1, 1, 0);
    add(P, 10, 1, 1, 1,  8, 4, 0, 1, 0);
    add(P,  5, 1, 1, 1,  1, 5, 0, 0, 1);
    add(P,  8, 1, 1, 1,  1, 2, 0, 0, 1);
    add(P,  8, 1, 1, 1,  5, 2, 0, 0, 0);
    add(P, 13, 1, 1, 1,  1, 1, 0, 0, 1);
    add(P,  4, 1, 1, 1,  1, 3, 0, 0, 1);
    add(P,  3, 1, 1, 1,  1, 0, 0, 0, 1);
    add(P, 16, 1, 1, 0,  1, 6, 0, 0, 1);
    add(P,  2, 1, 1, 1,  1, 6, 0, 1, 0);
    add(P,  2, 1, 1, 1,  1, 1, 0, 1, 1);
    add(P, 16, 1, 1, 0,  1, 6, 0, 1, 1);
    add(P,  0, 0, 0, 0,  4, 6, 1, 1, 0);
    add(P,  0, 0, 0, 0,  8, 6, 3, 1, 0);
    add(P,  0, 0, 0, 0,  4, 6, 0, 1, 0);
    add(P,  0, 0, 1, 0,  1, 0, 0, 1, 1);
    add(P, 16, 1, 0, 0,  1, 0, 0, 1, 0);
    add(P,  2, 1, 1, 1,  1, 1, 0, 1, 1);
    add(P,  2, 1, 1, 1, 12, 1, 3, 1, 0);
    add(O,  2, 1, 1, 1,  1, 0, 0, 1, 1);
    add(O,  1, 1, 1, 1,  3, 0, 0, 1, 0);
    add(P,  1, 1, 1, 1,  1, 1, 0, 0, 1);

    doReset();
    chk("reset state", int'(animState), 0);
    chk("reset frame", int'(animFrame), 0);
    chk("reset facing", int'(facing), 1);
    chk("reset stateChanged", int'(stateChanged), 0);
    chk("reset deadDone", int'(deadDone), 0);

    foreach (vq[i]) begin
      gameState    = vq[i].gs;
      keycode      = vq[i].key;
      keyPress     = vq[i].kp;
      onPlatform   = vq[i].onP;
      playerMoving = vq[i].mov;
      for (int t = 0; t < vq[i].n; t++) tick();
      chk($sformatf("row%0d state", i), int'(animState), int'(vq[i].st));
      chk($sformatf("row%0d frame", i), int'(animFrame), int'(vq[i].fr));
      chk($sformatf("row%0d facing", i), int'(facing), int'(vq[i].fac));
      chk($sformatf("row%0d stateChanged", i), int'(stateChanged), int'(vq[i].chg));
      chk($sformatf("row%0d deadDone", i), int'(deadDone), 0);
    end

    // stateChanged lasts exactly one Clk.
    keyPress = 1'b0;
    tick();
    chk("pulse state", int'(animState), 0);
    chk("pulse high", int'(stateChanged), 1);
    @(negedge Clk);
    chk("pulse low", int'(stateChanged), 0);

    // Key changes between ticks must not touch the outputs.
    keycode = 5'd2;
    keyPress = 1'b1;
    playerMoving = 1'b1;
    repeat (5) @(negedge Clk);
    chk("between ticks state", int'(animState), 0);
    chk("between ticks facing", int'(facing), 0);
    tick();
    chk("after tick state", int'(animState), 1);
    chk("after tick facing", int'(facing), 1);

    // Reset in the same cycle as a tick wins.
    repeat (3) tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset vs tick state", int'(animState), 0);
    chk("reset vs tick changed", int'(stateChanged), 0);
    Reset = 1'b0;
    frame_clk = 1'b0;
    @(negedge Clk);
    chk("reset vs tick settled", int'(animState), 0);
    tick();
    chk("post reset run", int'(animState), 1);
    chk("post reset frame", int'(animFrame), 0);

`ifdef PLAYER_DEATH_ANIM_EN
    keycode = 5'd16;
    onPlatform = 1'b1;
    tick();
    chk("dead jump entry", int'(animState), 6);
    keycode = 5'd0;
    onPlatform = 1'b0;
    hit = 1'b1;
    tick();
    chk("dead entry", int'(animState), 7);
    chk("dead entry frame", int'(animFrame), 0);
    chk("dead entry changed", int'(stateChanged), 1);
    chk("dead entry done", int'(deadDone), 0);
    hit = 1'b0;
    repeat (4) tick();
    chk("dead frame1", int'(animFrame), 1);
    chk("dead frame1 done", int'(deadDone), 0);
    repeat (4) tick();
    chk("dead frame2", int'(animFrame), 2);
    chk("dead frame2 done", int'(deadDone), 1);
    keycode = 5'd2;
    onPlatform = 1'b1;
    repeat (8) tick();
    chk("dead sticky", int'(animState), 7);
    chk("dead saturate", int'(animFrame), 2);
    chk("dead done held", int'(deadDone), 1);
    doReset();
    chk("dead reset state", int'(animState), 0);
    chk("dead reset done", int'(deadDone), 0);
    hit = 1'b1;
    tick();
    chk("dead reentry", int'(animState), 7);
    hit = 1'b0;
    gameState = 2'd0;
    tick();
    chk("dead leave play", int'(animState), 0);
    chk("dead leave done", int'(deadDone), 0);
`else
    keycode = 5'd0;
    hit = 1'b1;
    tick();
    chk("hit ignored state", int'(animState), 0);
    chk("hit ignored done", int'(deadDone), 0);
    tick();
    chk("hit ignored again", int'(animState), 0);
    hit = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
